// File: rtl/periph_bus_bridge.sv
// Byte-stream debug bridge: decodes read/write commands from a valid/ready byte
// link and acts as initiator on the peripheral register bus (A/WD/WE/RD).
module periph_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [4:0]  A,
  output logic [31:0] WD,
  output logic        WE,
  input  logic [31:0] RD
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] RESP_OK  = 8'hAA;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_RD_SETUP,
    S_RD_CAP,
    S_TX,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt;
  logic [1:0]    tx_idx;
  logic [31:0]   shift_q;
  logic [31:0]   cap_q;
  logic [4:0]    addr_pend;
  logic [7:0]    resp_q;
  logic [TW-1:0] to_cnt;
  logic          cmd_bad;

  assign cmd_bad = (rx_data[6:5] != 2'b00) || (rx_data[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    WE       = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (cmd_bad)         state_d = S_RESP;
          else if (rx_data[7]) state_d = S_WDATA;
          else                 state_d = S_RD_SETUP;
        end
      end
      S_WDATA: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_d = S_WRITE;
        end else if (to_cnt == TO_MAX) begin
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        WE      = 1'b1;
        state_d = S_RESP;
      end
      S_RD_SETUP: state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_TX;
      S_TX: begin
        tx_valid = 1'b1;
        tx_data  = cap_q[{tx_idx, 3'b000} +: 8];
        if (tx_ready && tx_idx == 2'd3) state_d = S_IDLE;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        tx_data  = resp_q;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write address/data are committed to the bus only with the 4th data byte,
  // so an aborted write leaves A and WD untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= '0;
      tx_idx    <= '0;
      shift_q   <= '0;
      cap_q     <= '0;
      addr_pend <= '0;
      resp_q    <= '0;
      to_cnt    <= '0;
      A         <= '0;
      WD        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
            if (cmd_bad)         resp_q    <= RESP_ERR;
            else if (rx_data[7]) addr_pend <= rx_data[4:0];
            else                 A         <= rx_data[4:0];
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            shift_q  <= {rx_data, shift_q[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            to_cnt   <= '0;
            if (byte_cnt == 2'd3) begin
              WD <= {rx_data, shift_q[31:8]};
              A  <= addr_pend;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TO_MAX) resp_q <= RESP_ERR;
          end
        end
        S_WRITE: resp_q <= RESP_OK;
        S_RD_CAP: begin
          cap_q  <= RD;
          tx_idx <= '0;
        end
        S_TX: begin
          if (tx_ready) tx_idx <= tx_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Directed self-checking bench for periph_bus_bridge (TIMEOUT_CYCLES = 16).
module tb_periph_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  periph_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .A        (A),
    .WD       (WD),
    .WE       (WE),
    .RD       (RD)
  );

  always #5 clk = ~clk;

  // Peripheral read model
  always_comb begin
    case (A)
      5'd8:    RD = 32'hDEADBEEF;
      5'd12:   RD = 32'h11223344;
      default: RD = 32'hA5A50000 | {27'd0, A};
    endcase
  end

  always @(posedge clk) if (WE === 1'b1) we_count <= we_count + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte and return one cycle after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      step();
      n++;
    end
    check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] word);
    int base = we_count;
    send_byte({3'b100, addr});
    for (int i = 0; i < 4; i++) send_byte(word[8*i +: 8]);
    check("wr_we_high", {31'd0, WE}, 32'd1);
    check("wr_addr", {27'd0, A}, {27'd0, addr});
    check("wr_wd", WD, word);
    check("wr_no_tx_yet", {31'd0, tx_valid}, 32'd0);
    step();
    check("wr_we_low", {31'd0, WE}, 32'd0);
    check("wr_ack_valid", {31'd0, tx_valid}, 32'd1);
    check("wr_ack_data", {24'd0, tx_data}, 32'h000000AA);
    step();
    check("wr_ack_done", {31'd0, tx_valid}, 32'd0);
    check("wr_we_once", we_count - base, 32'd1);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] word);
    int base = we_count;
    send_byte({3'b000, addr});
    check("rd_addr", {27'd0, A}, {27'd0, addr});
    check("rd_lat1", {31'd0, tx_valid}, 32'd0);
    step();
    check("rd_lat2", {31'd0, tx_valid}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("rd_valid", {31'd0, tx_valid}, 32'd1);
      check("rd_byte", {24'd0, tx_data}, {24'd0, word[8*i +: 8]});
      check("rd_rx_blocked", {31'd0, rx_ready}, 32'd0);
      step();
    end
    check("rd_done", {31'd0, tx_valid}, 32'd0);
    check("rd_no_we", we_count - base, 32'd0);
  endtask

  task automatic do_bad(input logic [7:0] cmd);
    int base = we_count;
    send_byte(cmd);
    check("bad_valid", {31'd0, tx_valid}, 32'd1);
    check("bad_data", {24'd0, tx_data}, 32'h000000EE);
    step();
    check("bad_done", {31'd0, tx_valid}, 32'd0);
    check("bad_no_we", we_count - base, 32'd0);
  endtask

  initial begin
    logic [7:0] got [4];
    int base, n, cyc, stall_bad, rx_bad;
    logic       prev_stall;
    logic [7:0] prev_data;

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    check("rst_A", {27'd0, A}, 32'd0);
    check("rst_WD", WD, 32'd0);
    check("rst_WE", {31'd0, WE}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Write 0x0F to address 4
    do_write(5'd4, 32'h0000000F);

    // Read 0xDEADBEEF from address 8; WD holds its last value
    do_read(5'd8, 32'hDEADBEEF);
    check("wd_hold", WD, 32'h0000000F);

    // Bad commands, then a normal read
    do_bad(8'h85);
    do_bad(8'h20);
    check("bad_A_hold", {27'd0, A}, 32'd8);
    do_read(5'd8, 32'hDEADBEEF);

    // Timeout after 16 idle cycles inside a partial write
    base = we_count;
    send_byte(8'h90);
    send_byte(8'h11);
    for (int i = 0; i < 15; i++) step();
    check("to_not_yet", {31'd0, tx_valid}, 32'd0);
    check("to_still_rx", {31'd0, rx_ready}, 32'd1);
    step();
    check("to_resp_valid", {31'd0, tx_valid}, 32'd1);
    check("to_resp_data", {24'd0, tx_data}, 32'h000000EE);
    check("to_wd_hold", WD, 32'h0000000F);
    check("to_A_hold", {27'd0, A}, 32'd8);
    step();
    check("to_no_we", we_count - base, 32'd0);
    do_read(5'd0, 32'hA5A50000);

    // Read under random back-pressure
    tx_ready = 1'b0;
    send_byte(8'h0C);
    n = 0;
    cyc = 0;
    stall_bad = 0;
    rx_bad = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    while (n < 4 && cyc < 300) begin
      if (rx_ready) rx_bad++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_bad++;
      tx_ready = (cyc > 200) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        got[n] = tx_data;
        n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      step();
      cyc++;
    end
    tx_ready = 1'b1;
    check("bp_count", n, 32'd4);
    check("bp_b0", {24'd0, got[0]}, 32'h44);
    check("bp_b1", {24'd0, got[1]}, 32'h33);
    check("bp_b2", {24'd0, got[2]}, 32'h22);
    check("bp_b3", {24'd0, got[3]}, 32'h11);
    check("bp_stable", stall_bad, 32'd0);
    check("bp_rx_blocked", rx_bad, 32'd0);
    check("bp_rx_ready_after", {31'd0, rx_ready}, 32'd1);

    // Reset in the middle of a write
    base = we_count;
    send_byte(8'h84);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_A", {27'd0, A}, 32'd0);
    check("mr_WD", WD, 32'd0);
    check("mr_WE", {31'd0, WE}, 32'd0);
    check("mr_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mr_tx_data", {24'd0, tx_data}, 32'd0);
    check("mr_rx_ready", {31'd0, rx_ready}, 32'd1);
    for (int i = 0; i < 20; i++) step();
    check("mr_no_resp", {31'd0, tx_valid}, 32'd0);
    check("mr_no_we", we_count - base, 32'd0);
    do_write(5'd8, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_bus_bridge.md
# periph_bus_bridge

Byte-stream debug bridge that acts as the initiator on the peripheral register bus (A/WD/WE/RD). It decodes read and write commands arriving on a valid/ready byte input. It issues the matching single-word bus transaction to the peripheral block, then returns an acknowledge or the read data on a valid/ready byte output. It sits between the host link (UART front end) and the peripheral block, in parallel with the CPU's bus port through the existing arbiter.

## Interface
- `TIMEOUT_CYCLES`, default 1_250_000: idle cycles allowed between bytes of an incomplete write command before it is aborted.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  incoming command/data byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  bridge accepts the byte; transfer occurs on the edge where `rx_valid && rx_ready`.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts the byte; transfer occurs on the edge where `tx_valid && tx_ready`.
- `A`  out  5  peripheral byte address.
- `WD`  out  32  write data.
- `WE`  out  1  write strobe, one cycle per write.
- `RD`  in  32  read data; combinational function of `A` in the peripheral block.

## Operation
- Command byte format:
  - bit7 = 1 write, 0 read.
  - bits6:5 must be 00.
  - bits4:0 = address `A`; bits1:0 must be 00 (word aligned).
- Write command: the command byte is followed by 4 data bytes, little-endian (first byte → WD[7:0]). After the 4th byte, `WE` pulses and the response 0xAA is sent.
- Read command: the bus is read at `A`, then 4 response bytes are sent, little-endian.
- Bad command byte (bits6:5 ≠ 00 or bits1:0 ≠ 00):
  - The byte is consumed.
  - No bus activity; `WE` stays 0.
  - Response 0xEE.
  - Any following bytes are parsed as new commands.
- FSM states and transitions:
  - IDLE: `rx_ready` = 1. On byte accept:
    - write → WDATA, byte counter = 0;
    - read → RD_SETUP;
    - bad → RESP with 0xEE.
  - WDATA: `rx_ready` = 1. Each accepted byte is shifted into the data register and the counter increments. After the 4th byte → WRITE. The timeout counter clears on every accepted byte. If it reaches `TIMEOUT_CYCLES` → RESP with 0xEE; partial data is discarded and `WD` is not updated.
  - WRITE: `WE` = 1 for exactly this cycle, with `A` and `WD` stable → RESP with 0xAA.
  - RD_SETUP: drives `A` for one full cycle → RD_CAP.
  - RD_CAP: `RD` latched into the capture register at the end of this cycle → TX with byte index 0.
  - TX: sends capture bytes 0..3. Index increments on each tx handshake; after byte 3 → IDLE.
  - RESP: sends a single byte; on handshake → IDLE.
- Bus output rules:
  - `A` and `WD` hold their last values after a transaction; they do not return to 0.
  - `WE` is never asserted during reads or errors.
- Valid/ready rules:
  - `rx_ready` = 0 in WRITE, RD_SETUP, RD_CAP, TX and RESP; no command pipelining.
  - `tx_valid` stays high and `tx_data` stays stable until `tx_ready`. `tx_ready` back-pressure may stall indefinitely; there is no timeout in TX or RESP.

## Timing
- Reset state (synchronous with `rst_n` low at an edge):
  - FSM → IDLE.
  - `A` = 0, `WD` = 0, `WE` = 0, `tx_valid` = 0, `tx_data` = 0.
  - `rx_ready` = 1 from the first cycle after release.
- Reset mid-operation: aborts any transaction at that edge. `WE` is low from that edge, no response is sent, and pending bytes are lost.
- Write latency: 4th data byte accepted at edge N → `WE` = 1 during cycle N+1 → `tx_valid` = 1 with 0xAA from cycle N+2.
- Read latency: command accepted at edge N → `A` valid cycle N+1 → `RD` captured end of cycle N+2 → `tx_valid` = 1 with byte 0 from cycle N+3.
- Zero-bubble transmit: a TX byte handshake at edge M presents the next byte in cycle M+1.
- Timeout: abort when exactly `TIMEOUT_CYCLES` consecutive WDATA cycles pass without an accepted byte. The counter width must hold `TIMEOUT_CYCLES`.

## Test plan
- Write DOUT: bytes 0x84, 0x0F, 0x00, 0x00, 0x00 with `tx_ready` = 1.
  - `WE` high exactly one cycle, `A` = 4, `WD` = 0x0000000F.
  - 0xAA sent two cycles after the last byte.
- Read: `RD` model returns 0xDEADBEEF at `A` = 8; send 0x08.
  - `tx` emits EF, BE, AD, DE.
  - First `tx_valid` 3 cycles after the command; `WE` never asserted.
- Bad commands: 0x85 (unaligned) and 0x20 (bits6:5 ≠ 00).
  - Each yields 0xEE, no `WE`.
  - A following valid read executes normally.
- Timeout: `TIMEOUT_CYCLES` = 16; send 0x90, 0x11, then idle 16 cycles.
  - 0xEE sent, `WE` never high, `WD` unchanged.
  - The next byte is parsed as a command.
- Back-pressure: read with `tx_ready` toggling randomly.
  - `tx_data` stable while `tx_valid && !tx_ready`.
  - All 4 bytes delivered in order; `rx_ready` = 0 until done.
- Reset mid-write after 2 data bytes: pulse `rst_n` low one cycle.
  - Outputs return to reset values, no `WE`, no response.
  - A fresh write then completes with 0xAA.
